// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback path: register index, data word
// and the per-requester writeback payload.
package regfile_wb_arbiter_pkg;

    typedef logic [31:0] uint32_t;
    typedef logic [4:0]  reg_idx_t;

    localparam int NUM_ARCH_REGS = 32;

    typedef struct packed {
        reg_idx_t rd;
        uint32_t  data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found scanning
// upward from the slot after i_ptr. The pointer register belongs to the caller.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        int  w_slot;
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_slot  = 0;
        for (int k = 1; k <= N; k++) begin
            w_slot = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_slot]) begin
                w_found         = 1'b1;
                o_grant[w_slot] = 1'b1;
                o_idx           = IDX_W'(w_slot);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write port of the integer register file: round-robin writeback
// arbitration, one registered write per cycle, and a RAW/WAW busy scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic                    wb_we,
    output logic [4:0]              wb_rd,
    output logic [31:0]             wb_data,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    output logic                    issue_ready,
    input  logic [4:0]              rs1_index,
    input  logic [4:0]              rs2_index,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic [31:0]             busy_vec
);

    wb_req_t                  w_req [NUM_REQ];
    wb_req_t                  w_sel;
    logic [NUM_REQ-1:0]       w_grant;
    logic [IDX_W-1:0]         w_gidx;
    logic                     w_accept;
    logic [NUM_ARCH_REGS-1:0] w_busy_nxt;

    logic [IDX_W-1:0]         r_ptr;
    logic                     r_we;
    reg_idx_t                 r_rd;
    uint32_t                  r_data;
    logic [NUM_ARCH_REGS-1:0] r_busy;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req[i].rd   = req_rd[i*5 +: 5];
            w_req[i].data = req_data[i*32 +: 32];
        end
    end

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign req_ready = rst ? '0 : w_grant;
    assign w_accept  = |req_ready;
    assign w_sel     = w_req[w_gidx];

    assign issue_ready = !r_busy[issue_rd] || (issue_rd == 5'd0);
    assign rs1_busy    = r_busy[rs1_index];
    assign rs2_busy    = r_busy[rs2_index];
    assign busy_vec    = r_busy;

    // Clear comes from the registered write so dependents wake only once the
    // value is in the register file; a same-edge issue of that index wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we && r_rd != 5'd0)
            w_busy_nxt[r_rd] = 1'b0;
        if (issue_valid && issue_ready && issue_rd != 5'd0)
            w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= IDX_W'(NUM_REQ - 1);
            r_we   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_accept && (w_sel.rd != 5'd0);
            if (w_accept) begin
                r_ptr  <= w_gidx;
                r_rd   <= w_sel.rd;
                r_data <= w_sel.data;
            end
        end
    end

    assign wb_we   = r_we;
    assign wb_rd   = r_rd;
    assign wb_data = r_data;

endmodule
